// File: rtl/apb_master_bridge_if.sv
// Command, response and APB signal bundle for apb_master_bridge.
// The master modport is the bridge's view; slave is the command source and APB slave side.
interface apb_master_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    logic [ADDR_W-1:0] P_addr;
    logic              P_selx;
    logic              P_enable;
    logic              P_write;
    logic [DATA_W-1:0] P_wdata;
    logic              P_ready;
    logic              P_slverr;
    logic [DATA_W-1:0] P_rdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               P_ready, P_slverr, P_rdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               P_addr, P_selx, P_enable, P_write, P_wdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               P_ready, P_slverr, P_rdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               P_addr, P_selx, P_enable, P_write, P_wdata
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding command-to-APB master with a wait-state watchdog.
// state  | meaning
// IDLE   | cmd_ready high, APB bus idle, waiting for a command
// SETUP  | APB setup phase (P_selx=1, P_enable=0), always one cycle
// ACCESS | APB access phase, waiting for P_ready or watchdog expiry
// RESP   | response held on rsp_* until rsp_ready
module apb_master_bridge #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WAIT_MAX = 16
) (
    input logic                 P_clk,
    input logic                 P_rst,
    apb_master_bridge_if.master bus
);
    localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              write_q;
    logic              selx_q;
    logic              enable_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic              rsp_timeout_q;

    assign bus.cmd_ready   = (state == IDLE);
    assign bus.P_addr      = addr_q;
    assign bus.P_write     = write_q;
    assign bus.P_wdata     = wdata_q;
    assign bus.P_selx      = selx_q;
    assign bus.P_enable    = enable_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

    always_ff @(posedge P_clk) begin
        if (P_rst) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            write_q       <= 1'b0;
            selx_q        <= 1'b0;
            enable_q      <= 1'b0;
            rdata_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        addr_q   <= bus.cmd_addr;
                        write_q  <= bus.cmd_write;
                        wdata_q  <= bus.cmd_wdata;
                        selx_q   <= 1'b1;
                        enable_q <= 1'b0;
                        wait_cnt <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    enable_q <= 1'b1;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (bus.P_ready) begin
                        rdata_q       <= write_q ? '0 : bus.P_rdata;
                        rsp_err_q     <= bus.P_slverr;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        selx_q        <= 1'b0;
                        enable_q      <= 1'b0;
                        state         <= RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // this edge would be the WAIT_MAX-th wait state: abort
                        rdata_q       <= '0;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        selx_q        <= 1'b0;
                        enable_q      <= 1'b0;
                        state         <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed and random transfers against an APB memory
// slave model, with expected responses computed from a simple memory/watchdog model.
module tb_apb_master_bridge;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int WAIT_MAX = 16;

    logic P_clk = 1'b0;
    logic P_rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    logic [31:0] mem [logic [31:0]];

    apb_master_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_master_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_MAX(WAIT_MAX)) dut (
        .P_clk (P_clk),
        .P_rst (P_rst),
        .bus   (bus.master)
    );

    always #5 P_clk = ~P_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    task automatic noise();
        bus.P_ready  = 1'($urandom);
        bus.P_slverr = 1'($urandom);
        bus.P_rdata  = $urandom;
    endtask

    // One complete transfer: waits = number of ACCESS cycles the slave holds P_ready low,
    // bp = cycles of response backpressure with a competing command held on cmd_valid.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input logic slverr, input int bp);
        logic        to;
        int          exp_en;
        int          n_en;
        logic [31:0] exp_rdata;
        to        = (waits >= WAIT_MAX);
        exp_en    = to ? WAIT_MAX : waits + 1;
        exp_rdata = (!wr && !to) ? mem_rd(addr) : 32'h0;

        @(negedge P_clk);
        chk("idle_cmd_ready", bus.cmd_ready, 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        @(negedge P_clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr  = $urandom;
        bus.cmd_wdata = $urandom;
        chk("setup_selx", bus.P_selx, 32'd1);
        chk("setup_enable", bus.P_enable, 32'd0);
        chk("setup_addr", bus.P_addr, addr);
        chk("setup_write", bus.P_write, 32'(wr));
        chk("setup_wdata", bus.P_wdata, wdata);
        chk("setup_cmd_ready", bus.cmd_ready, 32'd0);
        noise();
        @(negedge P_clk);

        n_en = 0;
        while (bus.P_enable === 1'b1 && n_en < WAIT_MAX + 2) begin
            chk("access_selx", bus.P_selx, 32'd1);
            chk("access_addr", bus.P_addr, addr);
            chk("access_write", bus.P_write, 32'(wr));
            chk("access_wdata", bus.P_wdata, wdata);
            bus.P_ready  = (n_en >= waits);
            bus.P_slverr = slverr;
            bus.P_rdata  = wr ? $urandom : mem_rd(addr);
            n_en++;
            @(negedge P_clk);
        end
        chk("enable_cycles", n_en, exp_en);
        noise();
        if (wr && !to && !slverr) mem[addr] = wdata;

        chk("rsp_valid", bus.rsp_valid, 32'd1);
        chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
        chk("rsp_err", bus.rsp_err, 32'(to | slverr));
        chk("rsp_timeout", bus.rsp_timeout, 32'(to));
        chk("rsp_selx", bus.P_selx, 32'd0);
        chk("rsp_enable", bus.P_enable, 32'd0);
        chk("rsp_cmd_ready", bus.cmd_ready, 32'd0);

        for (int i = 0; i < bp; i++) begin
            bus.rsp_ready = 1'b0;
            bus.cmd_valid = 1'b1;
            bus.cmd_write = 1'b1;
            bus.cmd_addr  = addr + 32'd100;
            noise();
            @(negedge P_clk);
            chk("bp_rsp_valid", bus.rsp_valid, 32'd1);
            chk("bp_rsp_rdata", bus.rsp_rdata, exp_rdata);
            chk("bp_rsp_err", bus.rsp_err, 32'(to | slverr));
            chk("bp_rsp_timeout", bus.rsp_timeout, 32'(to));
            chk("bp_cmd_ready", bus.cmd_ready, 32'd0);
            chk("bp_selx", bus.P_selx, 32'd0);
        end

        bus.rsp_ready = 1'b1;
        @(negedge P_clk);
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        chk("post_rsp_valid", bus.rsp_valid, 32'd0);
        chk("post_cmd_ready", bus.cmd_ready, 32'd1);
        chk("post_selx", bus.P_selx, 32'd0);
        chk("post_enable", bus.P_enable, 32'd0);
        chk("post_addr_hold", bus.P_addr, addr);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.P_ready   = 1'b0;
        bus.P_slverr  = 1'b0;
        bus.P_rdata   = '0;

        repeat (3) @(posedge P_clk);
        @(negedge P_clk);
        chk("reset_selx", bus.P_selx, 32'd0);
        chk("reset_enable", bus.P_enable, 32'd0);
        chk("reset_addr", bus.P_addr, 32'd0);
        chk("reset_rsp_valid", bus.rsp_valid, 32'd0);
        chk("reset_rsp_err", bus.rsp_err, 32'd0);
        chk("reset_cmd_ready", bus.cmd_ready, 32'd1);
        P_rst = 1'b0;

        xfer(1'b1, 32'd1, 32'd7, 0, 1'b0, 0);
        xfer(1'b1, 32'd2, 32'd5, 0, 1'b0, 0);
        xfer(1'b0, 32'd2, 32'd0, 0, 1'b0, 0);
        xfer(1'b1, 32'd3, 32'hA5, 0, 1'b0, 0);
        xfer(1'b0, 32'd3, 32'd0, 3, 1'b0, 0);
        xfer(1'b1, 32'd4, 32'h1234, 0, 1'b1, 0);
        xfer(1'b0, 32'd1, 32'd0, 0, 1'b1, 0);
        xfer(1'b0, 32'd2, 32'd0, WAIT_MAX, 1'b0, 0);
        xfer(1'b1, 32'd5, 32'hDEAD, WAIT_MAX - 1, 1'b0, 0);
        xfer(1'b0, 32'd1, 32'd0, 1, 1'b0, 5);

        // reset while the access phase is stalled
        @(negedge P_clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'd6;
        bus.cmd_wdata = 32'h66;
        @(negedge P_clk);
        bus.cmd_valid = 1'b0;
        bus.P_ready   = 1'b0;
        @(negedge P_clk);
        chk("rst_pre_enable", bus.P_enable, 32'd1);
        P_rst = 1'b1;
        @(negedge P_clk);
        P_rst = 1'b0;
        chk("rst_selx", bus.P_selx, 32'd0);
        chk("rst_enable", bus.P_enable, 32'd0);
        chk("rst_addr", bus.P_addr, 32'd0);
        chk("rst_rsp_valid", bus.rsp_valid, 32'd0);
        @(negedge P_clk);
        chk("rst_release_cmd_ready", bus.cmd_ready, 32'd1);
        chk("rst_release_rsp_valid", bus.rsp_valid, 32'd0);
        xfer(1'b0, 32'd6, 32'd0, 0, 1'b0, 0);

        for (int t = 0; t < 40; t++) begin
            logic        wr;
            logic [31:0] addr;
            int          waits;
            wr    = 1'($urandom);
            addr  = 32'($urandom_range(0, 7));
            waits = ($urandom_range(0, 7) == 0) ? WAIT_MAX + int'($urandom_range(0, 3))
                                                 : int'($urandom_range(0, 4));
            xfer(wr, addr, $urandom, waits, ($urandom_range(0, 4) == 0), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Command-to-APB master that drives the ampa_apb memory slave. Accepts single read/write commands on a valid/ready interface, runs the APB SETUP and ACCESS phases, waits for P_ready, and returns read data and error status on a response valid/ready interface. A wait-state watchdog aborts transfers whose P_ready never arrives.

Parameters:
ADDR_W, 32, APB address width
DATA_W, 32, APB data width
WAIT_MAX, 16, maximum ACCESS cycles with P_ready=0 before timeout abort (>=1)

Ports:
P_clk  input  1  clock, all logic on rising edge
P_rst  input  1  synchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  bridge can accept command
cmd_write  input  1  1=write, 0=read
cmd_addr  input  ADDR_W  transfer address
cmd_wdata  input  DATA_W  write data (ignored for reads)
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_rdata  output  DATA_W  read data (0 for writes/timeout)
rsp_err  output  1  P_slverr sampled at completion, or timeout
rsp_timeout  output  1  transfer aborted by watchdog
P_addr  output  ADDR_W  APB address
P_selx  output  1  APB select
P_enable  output  1  APB enable
P_write  output  1  APB direction
P_wdata  output  DATA_W  APB write data
P_ready  input  1  slave ready
P_slverr  input  1  slave error
P_rdata  input  DATA_W  slave read data

Behaviour:
- Reset (P_rst=1 at edge): state IDLE; all outputs 0 except cmd_ready=1 on the following cycle; wait counter 0.
- FSM states: IDLE, SETUP, ACCESS, RESP. All APB and rsp outputs registered.
- IDLE: cmd_ready=1. cmd_valid&cmd_ready at edge N -> latch cmd into P_addr/P_write/P_wdata, P_selx=1, P_enable=0, go SETUP (cycle N+1).
- SETUP: exactly one cycle; cmd_ready=0; next edge P_enable=1 -> ACCESS.
- ACCESS: P_selx=1, P_enable=1, P_addr/P_write/P_wdata stable. At an edge with P_ready=1: capture rsp_rdata=P_rdata if read else 0, rsp_err=P_slverr, rsp_timeout=0; drop P_selx/P_enable; go RESP.
- Wait states: each ACCESS edge with P_ready=0 increments counter. When counter would reach WAIT_MAX: abort, drop P_selx/P_enable, rsp_err=1, rsp_timeout=1, rsp_rdata=0, go RESP. Counter clears on entering SETUP.
- Zero-wait latency: cmd accept edge N -> SETUP N+1 -> ACCESS N+2 -> rsp_valid=1 from cycle N+3.
- RESP: rsp_valid=1, rsp fields stable until rsp_valid&rsp_ready edge -> IDLE, rsp_valid=0. cmd_ready=0 throughout (one transfer outstanding max). Minimum command spacing: 4 cycles.
- Idle bus: P_selx=P_enable=0; P_addr/P_write/P_wdata hold last values.
- P_ready/P_slverr/P_rdata ignored outside ACCESS.
- P_enable never asserted without P_selx; P_enable never asserted in the cycle P_selx first rises.
- Reset mid-operation (any state): next edge -> IDLE, APB outputs 0, in-flight command discarded, no response issued.
- cmd_valid while not IDLE: ignored, not captured.

Test Plan:
- Write: cmd write addr=1 wdata=7, P_ready tied 1 -> P_selx high 2 cycles, P_enable high 1 cycle, P_addr=1/P_wdata=7/P_write=1 stable; rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
- Read with slave: write addr=2 data=5 then read addr=2 on ampa_apb -> rsp_rdata=5, rsp_err=0, P_write=0 during read phases.
- Wait states: P_ready held 0 for 3 ACCESS cycles then 1 with P_rdata=0xA5 -> P_enable high 4 cycles, rsp_rdata=0xA5, rsp_timeout=0.
- Slave error and timeout: P_slverr=1 with P_ready=1 -> rsp_err=1, rsp_timeout=0; P_ready stuck 0 with WAIT_MAX=16 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, P_selx=0.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and fields stable, cmd_ready=0, second cmd_valid not accepted until rsp handshake.
- Reset mid-ACCESS: P_rst=1 one cycle while P_enable=1 -> next cycle P_selx=P_enable=0, rsp_valid=0, cmd_ready=1 after reset released.
